// File: rtl/lsu.sv
// Load/store unit: one exu request at a time over a valid/ready data bus.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        wen_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wmask_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("lsu: TIMEOUT_CYCLES must lie in 1..255");
    end

    state_t      state_q, state_d;
    logic        wen_q;
    logic [31:2] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic [31:0] rdata_q;
    logic        timeout;
    logic        accept;

    // Only word addresses go on the bus; the byte offset is exu's business.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    assign accept = (state_q == IDLE) && req_i;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q;
    logic       err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (accept) begin
            cnt_q <= 8'd0;
        end else if (state_q == ADDR || state_q == RESP) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign timeout = (cnt_q == TIMEOUT_LIMIT);

    // Flag is captured only when the limit, not a bus completion, ends the wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout && ((state_q == ADDR && !bus_ready_i) ||
                                 (state_q == RESP && !bus_rvalid_i));
        end
    end

    assign err_o = err_q && (state_q == DONE);
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignment so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaults first; any path that leaves a variable unassigned infers a latch.
        state_d     = state_q;
        busy_o      = 1'b1;
        bus_valid_o = 1'b0;
        ack_o       = 1'b0;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (req_i) state_d = ADDR;
            end
            ADDR: begin
                bus_valid_o = 1'b1;
                if (bus_ready_i)  state_d = RESP;
                else if (timeout) state_d = DONE;
            end
            RESP: begin
                if (bus_rvalid_i) state_d = DONE;
                else if (timeout) state_d = DONE;
            end
            DONE: begin
                ack_o   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the request registers are reset so the bus fields read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            addr_q  <= 30'd0;
            wdata_q <= 32'd0;
            wmask_q <= 4'd0;
        end else if (accept) begin
            wen_q   <= wen_i;
            addr_q  <= addr_i[31:2];
            wdata_q <= wdata_i;
            wmask_q <= wmask_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
        end else if (state_q == RESP && bus_rvalid_i && !wen_q) begin
            rdata_q <= bus_rdata_i;
        end
    end

    assign rdata_o     = rdata_q;
    assign bus_we_o    = wen_q;
    assign bus_addr_o  = {addr_q, 2'b00};
    assign bus_wdata_o = wdata_q;
    assign bus_wstrb_o = wen_q ? wmask_q : 4'b0000;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized transactions
// against a latency/data reference model; define LSU_TIMEOUT_EN for watchdog tests.
module tb_lsu;

`ifdef LSU_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif
    localparam int NEVER = 9999;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i, wen_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  wmask_i;
    logic [31:0] rdata_o;
    logic        ack_o, err_o, busy_o, bus_valid_o, bus_ready_i, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .wen_i(wen_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .wmask_i(wmask_i), .rdata_o(rdata_o), .ack_o(ack_o),
        .err_o(err_o), .busy_o(busy_o), .bus_valid_o(bus_valid_o),
        .bus_ready_i(bus_ready_i), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_rdata;

    typedef struct {
        int          ack_cyc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
        int          valid_cycles;
        bit          stable;
        logic [31:0] rdata;
        logic        err;
        bit          pulse_ok;
    } obs_t;

    // Reference: bus handshake after r extra ADDR cycles, response after v extra
    // RESP cycles; with the watchdog, the wait is cut off once the counter that
    // starts at 0 in the first ADDR cycle reaches the limit without completion.
    function automatic int exp_ack_cycle(input int r, input int v);
        int normal = 3 + r + v;
`ifdef LSU_TIMEOUT_EN
        if (normal - 1 > TO + 1) return TO + 2;
`endif
        return normal;
    endfunction

    function automatic logic exp_err(input int r, input int v);
`ifdef LSU_TIMEOUT_EN
        return (3 + r + v - 1 > TO + 1);
`else
        return 1'b0;
`endif
    endfunction

    // Drives one request from IDLE; returns one cycle after the ack (back in IDLE).
    task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input int rdy_wait, input int rv_wait,
                          input logic [31:0] resp, input bit hold, output obs_t o);
        int c = 0, vcnt = 0, rcnt = 0;
        bit done = 0;
        o = '{default: 0};
        o.ack_cyc = -1;
        o.stable  = 1;
        req_i = 1'b1; wen_i = wen; addr_i = addr; wdata_i = wdata; wmask_i = mask;
        while (!done && c < 600) begin
            if (c == 1 && !hold) begin
                req_i = 1'b0; wen_i = ~wen; addr_i = 32'hFFFF_FFFC;
                wdata_i = $urandom; wmask_i = 4'($urandom);
            end
            bus_rdata_i  = $urandom;
            bus_ready_i  = 1'($urandom_range(0, 1));
            bus_rvalid_i = 1'($urandom_range(0, 1));
            if (bus_valid_o) begin
                bus_ready_i = (vcnt == rdy_wait);
                if (vcnt == 0) begin
                    o.addr = bus_addr_o; o.wdata = bus_wdata_o;
                    o.wstrb = bus_wstrb_o; o.we = bus_we_o;
                end else if ({bus_addr_o, bus_wdata_o, bus_wstrb_o, bus_we_o} !==
                             {o.addr, o.wdata, o.wstrb, o.we}) begin
                    o.stable = 0;
                end
                vcnt++;
            end else if (busy_o && !ack_o) begin
                bus_rvalid_i = (rcnt == rv_wait);
                if (bus_rvalid_i) bus_rdata_i = resp;
                rcnt++;
            end
            @(negedge clk);
            if (ack_o) begin
                o.ack_cyc = c; o.rdata = rdata_o; o.err = err_o; done = 1;
            end
            @(posedge clk); #1;
            c++;
        end
        o.valid_cycles = vcnt;
        o.pulse_ok = !ack_o && !busy_o;
        bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;
        if (!hold) req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_i = 1'b0; wen_i = 1'b0; addr_i = '0; wdata_i = '0; wmask_i = '0;
        bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ack_o, err_o, busy_o, bus_valid_o, bus_we_o, bus_wstrb_o} !== 9'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b exp 0", {ack_o, err_o, busy_o, bus_valid_o, bus_we_o, bus_wstrb_o});
        end
        checks++;
        if ({rdata_o, bus_addr_o, bus_wdata_o} !== 96'b0) begin
            failures++;
            $display("FAIL reset_data got %h %h %h exp 0", rdata_o, bus_addr_o, bus_wdata_o);
        end
        rst_n = 1'b1;
        exp_rdata = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_zero_wait();
        obs_t o;
        do_txn(1'b0, 32'h0000_1006, $urandom, 4'hF, 0, 0, 32'hDEAD_BEEF, 0, o);
        exp_rdata = 32'hDEAD_BEEF;
        checks++;
        if (o.ack_cyc != exp_ack_cycle(0, 0)) begin
            failures++; $display("FAIL load_ack_cycle got %0d exp %0d", o.ack_cyc, exp_ack_cycle(0, 0));
        end
        checks++;
        if ({o.addr, o.wstrb, o.we} !== {32'h0000_1004, 4'b0000, 1'b0}) begin
            failures++; $display("FAIL load_bus got addr=%h wstrb=%b we=%b exp 00001004 0000 0", o.addr, o.wstrb, o.we);
        end
        checks++;
        if (o.rdata !== exp_rdata) begin
            failures++; $display("FAIL load_rdata got %h exp %h", o.rdata, exp_rdata);
        end
        checks++;
        if (!o.pulse_ok || o.err !== 1'b0) begin
            failures++; $display("FAIL load_pulse got pulse_ok=%0d err=%b exp 1 0", o.pulse_ok, o.err);
        end
    endtask

    task automatic test_store_stall();
        obs_t o;
        logic [31:0] a = $urandom;
        do_txn(1'b1, a, 32'h00AB_0000, 4'b0100, 4, 0, $urandom, 0, o);
        checks++;
        if (o.ack_cyc != 7) begin
            failures++; $display("FAIL store_ack_cycle got %0d exp 7", o.ack_cyc);
        end
        checks++;
        if (o.valid_cycles != 5 || !o.stable) begin
            failures++; $display("FAIL store_valid got cycles=%0d stable=%0d exp 5 1", o.valid_cycles, o.stable);
        end
        checks++;
        if ({o.addr, o.wdata, o.wstrb, o.we} !== {a & 32'hFFFF_FFFC, 32'h00AB_0000, 4'b0100, 1'b1}) begin
            failures++; $display("FAIL store_bus got %h %h %b %b exp %h 00ab0000 0100 1", o.addr, o.wdata, o.wstrb, o.we, a & 32'hFFFF_FFFC);
        end
        checks++;
        if (o.rdata !== exp_rdata) begin
            failures++; $display("FAIL store_rdata_hold got %h exp %h", o.rdata, exp_rdata);
        end
    endtask

    task automatic test_input_change();
        obs_t o;
        do_txn(1'b1, 32'h2000_0012, 32'h1234_5678, 4'b0011, 3, 1, $urandom, 0, o);
        checks++;
        if (!o.stable || o.addr !== 32'h2000_0010 || o.we !== 1'b1 || o.wstrb !== 4'b0011) begin
            failures++; $display("FAIL input_change got addr=%h we=%b wstrb=%b stable=%0d exp 20000010 1 0011 1", o.addr, o.we, o.wstrb, o.stable);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int n = 0;
        logic [31:0] addr_b = 32'h0000_4ABF;
        logic [31:0] resp_b = $urandom;
        do_txn(1'b0, 32'h0000_3000, '0, 4'h0, 0, 0, 32'hCAFE_0001, 1, o);
        checks++;
        if (o.ack_cyc != 3 || o.rdata !== 32'hCAFE_0001) begin
            failures++; $display("FAIL b2b_first got ack=%0d rdata=%h exp 3 cafe0001", o.ack_cyc, o.rdata);
        end
        wen_i = 1'b0; addr_i = addr_b; wdata_i = $urandom;
        @(posedge clk); #1;
        checks++;
        if (bus_valid_o !== 1'b1 || bus_addr_o !== (addr_b & 32'hFFFF_FFFC) || bus_we_o !== 1'b0) begin
            failures++; $display("FAIL b2b_second_addr got valid=%b addr=%h we=%b exp 1 %h 0", bus_valid_o, bus_addr_o, bus_we_o, addr_b & 32'hFFFF_FFFC);
        end
        req_i = 1'b0; bus_ready_i = 1'b1;
        @(posedge clk); #1;
        bus_ready_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = resp_b;
        while (!ack_o && n < 10) begin
            @(posedge clk); #1; n++;
            bus_rvalid_i = 1'b0;
        end
        exp_rdata = resp_b;
        checks++;
        if (ack_o !== 1'b1 || rdata_o !== exp_rdata || n != 1) begin
            failures++; $display("FAIL b2b_second_done got ack=%b rdata=%h wait=%0d exp 1 %h 1", ack_o, rdata_o, n, exp_rdata);
        end
        bus_rvalid_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_resp();
        int bad = 0;
        req_i = 1'b1; wen_i = 1'b0; addr_i = 32'h0000_0100;
        @(posedge clk); #1;
        req_i = 1'b0; bus_ready_i = 1'b1;
        @(posedge clk); #1;
        bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        exp_rdata = 32'h0;
        checks++;
        if ({ack_o, err_o, busy_o, bus_valid_o, bus_we_o, bus_wstrb_o, rdata_o, bus_addr_o, bus_wdata_o} !== 105'b0) begin
            failures++; $display("FAIL reset_mid_resp got busy=%b valid=%b ack=%b rdata=%h addr=%h exp all 0", busy_o, bus_valid_o, ack_o, rdata_o, bus_addr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            bus_rvalid_i = 1'b1; bus_rdata_i = $urandom;
            @(posedge clk); #1;
            if (ack_o !== 1'b0 || busy_o !== 1'b0 || rdata_o !== exp_rdata) bad++;
        end
        bus_rvalid_i = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL stray_rvalid_idle got %0d bad cycles exp 0", bad);
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int i = 0; i < 40; i++) begin
            logic        wen  = 1'($urandom);
            logic [31:0] addr = $urandom;
            logic [31:0] wd   = $urandom;
            logic [3:0]  mask = 4'($urandom);
            logic [31:0] resp = $urandom;
            int          r    = $urandom_range(0, 3);
            int          v    = $urandom_range(0, 3);
            do_txn(wen, addr, wd, mask, r, v, resp, 0, o);
            if (!wen) exp_rdata = resp;
            checks++;
            if (o.ack_cyc != exp_ack_cycle(r, v) || o.valid_cycles != r + 1 || !o.stable || !o.pulse_ok) begin
                failures++; $display("FAIL rand_timing[%0d] got ack=%0d valid=%0d stable=%0d pulse=%0d exp ack=%0d valid=%0d", i, o.ack_cyc, o.valid_cycles, o.stable, o.pulse_ok, exp_ack_cycle(r, v), r + 1);
            end
            checks++;
            if ({o.addr, o.wdata, o.wstrb, o.we} !== {addr & 32'hFFFF_FFFC, wd, wen ? mask : 4'b0000, wen}) begin
                failures++; $display("FAIL rand_bus[%0d] got %h %h %b %b exp %h %h %b %b", i, o.addr, o.wdata, o.wstrb, o.we, addr & 32'hFFFF_FFFC, wd, wen ? mask : 4'b0000, wen);
            end
            checks++;
            if (o.rdata !== exp_rdata || o.err !== 1'b0) begin
                failures++; $display("FAIL rand_rdata[%0d] got %h err=%b exp %h 0", i, o.rdata, o.err, exp_rdata);
            end
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        int   rv[4] = '{NEVER, TO - 1, TO, 0};
        int   rr[4] = '{0, 0, 0, NEVER};
        for (int k = 0; k < 4; k++) begin
            logic [31:0] resp = $urandom;
            logic        e    = exp_err(rr[k], rv[k]);
            do_txn(1'b0, $urandom, $urandom, 4'hF, rr[k], rv[k], resp, 0, o);
            if (!e) exp_rdata = resp;
            checks++;
            if (o.ack_cyc != exp_ack_cycle(rr[k], rv[k]) || o.err !== e || o.rdata !== exp_rdata || !o.pulse_ok) begin
                failures++; $display("FAIL timeout[%0d] got ack=%0d err=%b rdata=%h exp ack=%0d err=%b rdata=%h", k, o.ack_cyc, o.err, o.rdata, exp_ack_cycle(rr[k], rv[k]), e, exp_rdata);
            end
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "tb_lsu watchdog expired");
    end

    initial begin
        test_reset();
        test_load_zero_wait();
        test_store_stall();
        test_input_change();
        test_back_to_back();
        test_reset_mid_resp();
        test_random();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
